adder32_issue_ctrl: RTL and testbench

- Sequential front/back-end for the combinational adder32 datapath.
- Buffers operand triples (a, b, ci) from an upstream valid/ready stream in a small FIFO, drives them onto the adder inputs, and holds them for a programmable multicycle settle window.
- Captures sum/carry and presents the result on a downstream valid/ready stream.
- Sits directly upstream (operand feed) and downstream (result capture) of adder32.

---
 rtl/adder32_pkg.sv | 33 +++
 rtl/adder32.sv | 20 ++
 rtl/adder32_opfifo.sv | 73 +++++++
 rtl/adder32_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_adder32_issue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder32_pkg.sv
// adder32_pkg: shared definitions for the adder32 issue/capture slice.
//   WIDTH      datapath width of adder32
//   ENTRY_W    width of one queued operand entry, layout {ci, b, a}
//   CNT_W      width of the settle-window down-counter (SETTLE up to 15)
//   state_e    issue-controller FSM states
//   op_entry_t operand entry as stored in the FIFO
//   signed_ovf two's-complement overflow of a + b (+ci) given the sum bits
package adder32_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned ENTRY_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic             ci;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] a;
    } op_entry_t;

    // Overflow iff both operands share a sign and the result sign differs.
    function automatic logic signed_ovf(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

endpackage

// File: rtl/adder32.sv
// adder32: combinational 32-bit adder with carry-in/carry-out.
//   a, b  operands
//   ci    carry-in
//   s     sum bits
//   co    carry-out
module adder32
    import adder32_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    end

endmodule

// File: rtl/adder32_opfifo.sv
// adder32_opfifo: synchronous operand FIFO, DEPTH entries of ENTRY_W bits.
//   clk, rst   clock, synchronous active-high reset
//   push       write push_data (ignored when full)
//   push_data  entry to write
//   full       no free entries
//   pop        advance the read pointer (ignored when empty)
//   pop_data   current head entry (valid when !empty)
//   empty      no stored entries
//   count      number of stored entries, $clog2(DEPTH)+1 bits
// A write is visible at the head only from the cycle after the push edge.
module adder32_opfifo
    import adder32_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]  count_q, count_d;
    logic               do_push, do_pop;

    assign full     = (count_q == CNT_FW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two DEPTH: pointer overflow is the modulo wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/adder32_issue_ctrl.sv
// adder32_issue_ctrl: operand feed and result capture around adder32.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream operand stream (in_a, in_b, in_ci)
//   add_a/add_b/add_ci  registered operands driven onto adder32
//   add_s/add_co        adder32 result
//   out_valid/out_ready downstream result stream (out_sum, out_co)
//   busy                FSM active or operands queued
//   out_ovf             signed overflow flag, only with ADDER32_OVF_FLAG_EN
// Operands are held on the adder for SETTLE cycles before the result is
// captured; a result held in HOLD is released on the downstream handshake,
// issuing the next queued entry in that same cycle.
module adder32_issue_ctrl
    import adder32_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ci,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             busy
`ifdef ADDER32_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    op_entry_t              op_q, op_d;
    logic                   valid_q, valid_d;
    logic [WIDTH-1:0]       sum_q, sum_d;
    logic                   co_q, co_d;

    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0]     fifo_head_bits;
    op_entry_t              fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    op_entry_t              in_entry;

    assign in_entry  = '{ci: in_ci, b: in_b, a: in_a};
    assign fifo_head = op_entry_t'(fifo_head_bits);

    adder32_opfifo #(
        .DEPTH (DEPTH)
    ) u_opfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_entry),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (fifo_head_bits),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef ADDER32_OVF_FLAG_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        valid_d  = valid_q;
        sum_d    = sum_q;
        co_d     = co_q;
        fifo_pop = 1'b0;
`ifdef ADDER32_OVF_FLAG_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_head;
                    cnt_d    = CNT_W'(SETTLE - 1);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    sum_d   = add_s;
                    co_d    = add_co;
`ifdef ADDER32_OVF_FLAG_EN
                    ovf_d   = signed_ovf(op_q.a, op_q.b, add_s);
`endif
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (!fifo_empty) begin
                        // Back-to-back issue: next operands go out on the
                        // same edge that retires the current result.
                        fifo_pop = 1'b1;
                        op_d     = fifo_head;
                        cnt_d    = CNT_W'(SETTLE - 1);
                        state_d  = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

`ifdef ADDER32_OVF_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
    assign out_ovf = ovf_q;
`endif

    assign in_ready  = !fifo_full;
    assign add_a     = op_q.a;
    assign add_b     = op_q.b;
    assign add_ci    = op_q.ci;
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_co    = co_q;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_adder32_issue_ctrl.sv
// Bench for adder32_issue_ctrl with adder32 tied to its add_* ports.
// Build with +define+ADDER32_OVF_FLAG_EN to include the overflow flag.
module tb_adder32_issue_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        in_ci;
    logic [31:0] add_a, add_b, add_s;
    logic        add_ci, add_co;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic        out_co;
    logic        busy;
`ifdef ADDER32_OVF_FLAG_EN
    logic        out_ovf;
`endif

    always #5 clk = ~clk;

    adder32_issue_ctrl #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .busy      (busy)
`ifdef ADDER32_OVF_FLAG_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    adder32 u_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     rise_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     push_cyc = 0;
    int     stall_cnt = 0;
    logic   prev_valid = 1'b0;
    logic [32:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: 33-bit unsigned sum and signed-range overflow test.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
        exp_t   e;
        longint full_u;
        longint full_s;
        full_u = longint'(a) + longint'(b) + longint'(ci);
        full_s = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        e.sum  = full_u[31:0];
        e.co   = full_u[32];
        e.ovf  = (full_s > 64'sd2147483647) || (full_s < -64'sd2147483648);
        return e;
    endfunction

    // Monitor: a result is consumed at the edge following a negedge where
    // out_valid && out_ready, so each result is compared exactly once.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_valid) rise_q.push_back(cyc);
                else chk("hold_stable", {31'b0, out_co, out_sum}, {31'b0, held});
                held = {out_co, out_sum};
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_sum", {32'b0, out_sum}, {32'b0, e.sum});
                        chk("out_co", {63'b0, out_co}, {63'b0, e.co});
`ifdef ADDER32_OVF_FLAG_EN
                        chk("out_ovf", {63'b0, out_ovf}, {63'b0, e.ovf});
`endif
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic ci);
        int waited;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_ci = ci;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            waited++;
            stall_cnt++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("push_timeout", 64'd1, 64'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(model(a, b, ci));
            #1;
            push_cyc = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || busy || out_valid); i++) @(negedge clk);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", {63'b0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_a [6];
        logic [31:0] bp_b [6];
        bit          rnd_done;
        int          lat;
        exp_t        first;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_ci = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_sum", {32'b0, out_sum}, 64'd0);
        chk("rst_out_co", {63'b0, out_co}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_add_a", {32'b0, add_a}, 64'd0);
        @(posedge clk);
        #1;

        // Single op with latency: counting the push cycle as cycle 1,
        // out_valid is first seen in cycle SETTLE+2.
        out_ready = 1'b1;
        push_op(32'd5, 32'd10, 1'b1);
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - push_cyc;
                break;
            end
        end
        chk("single_latency", 64'(lat), 64'(SETTLE + 1));
        chk("single_sum_direct", {32'b0, out_sum}, 64'd16);
        @(posedge clk);
        @(negedge clk);
        chk("single_busy_fall", {63'b0, busy}, 64'd0);
        drain();

        // Burst of 4: ordered results, SETTLE+1 spacing, no input stalls.
        rise_q.delete();
        stall_cnt = 0;
        push_op(32'd37, 32'd48, 1'b0);
        push_op(32'd125, 32'd110, 1'b1);
        push_op(32'd63, 32'd211, 1'b0);
        push_op(32'd122, 32'd11, 1'b1);
        chk("burst_no_stall", 64'(stall_cnt), 64'd0);
        drain();
        chk("burst_rises", 64'(rise_q.size()), 64'd4);
        for (int i = 1; i < rise_q.size(); i++)
            chk("burst_spacing", 64'(rise_q[i] - rise_q[i-1]), 64'(SETTLE + 1));

        // Backpressure: one op in the engine plus DEPTH queued fills the FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 32'd1000 * 32'(i + 1) + 32'd7;
            bp_b[i] = 32'd333 + 32'(i);
        end
        first = model(bp_a[0], bp_b[0], 1'b0);
        for (int i = 0; i < 5; i++) push_op(bp_a[i], bp_b[i], 1'(i));
        repeat (SETTLE + 3) @(negedge clk);
        chk("bp_in_ready_full", {63'b0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
        chk("bp_sum_first", {32'b0, out_sum}, {32'b0, first.sum});
        @(posedge clk);
        #1 out_ready = 1'b1;
        push_op(bp_a[5], bp_b[5], 1'b1);
        drain();

        // Carry / wrap corners
        push_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        push_op(32'h7FFF_FFFF, 32'd1, 1'b0);
        push_op(32'd127, 32'd127, 1'b1);
        push_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        drain();

        // Reset mid-SETTLE with two entries queued
        push_op(32'd1, 32'd2, 1'b0);
        push_op(32'd3, 32'd4, 1'b0);
        push_op(32'd5, 32'd6, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        @(posedge clk);
        #1;
        push_op(32'd100, 32'd200, 1'b0);
        drain();

        // Randomized traffic with random downstream backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] ra, rb;
                    ra = $urandom;
                    rb = $urandom;
                    if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 7) == 0) rb = 32'h7FFF_FFFF;
                    push_op(ra, rb, 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
